// File: rtl/bit_akis_pkg.sv
// Shared definitions for the bit_akis checker scheduler.
package bit_akis_pkg;

  localparam int unsigned DEF_DATA_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr, cyclically.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bit_akis_hakem.sv
// Round-robin scheduler sharing one bit_akis_kontrol checker among N_REQ requesters,
// with a done watchdog and a saturating error counter.
module bit_akis_hakem
  import bit_akis_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_err,
  output logic                    o_chk_flag,
  output logic [DATA_W-1:0]       o_chk_data,
  input  logic                    i_chk_err,
  input  logic                    i_chk_done,
  output logic                    o_busy,
  output logic                    o_timeout,
  output logic [CNT_W-1:0]        o_err_total
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                done_q;
  logic                flag_q, flag_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic                to_q, to_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                done_evt;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (i_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Only a rising edge of done counts, so a level left high from a previous job is ignored.
  assign done_evt = i_chk_done & ~done_q;

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    wdog_d  = wdog_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = ISSUE;
          gidx_d  = arb_idx;
          gnt_d   = arb_gnt;
          data_d  = i_req_data[int'(arb_idx)*DATA_W +: DATA_W];
          flag_d  = 1'b1;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_evt) begin
          state_d = RESP;
          ack_d   = gnt_q;
          err_d   = i_chk_err;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          ack_d   = gnt_q;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
        if (err_q && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      wdog_q  <= wdog_d;
      done_q  <= i_chk_done;
      flag_q  <= flag_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_chk_flag  = flag_q;
  assign o_chk_data  = data_q;
  assign o_busy      = busy_q;
  assign o_timeout   = to_q;
  assign o_err_total = cnt_q;

endmodule

// File: doc/bit_akis_hakem.md
# bit_akis_hakem

Round-robin scheduler that shares one `bit_akis_kontrol` checker instance among `N_REQ` requesters. It accepts one 3-bit word per requester request and issues it to the checker as a single-cycle flag pulse. It waits for the checker's done, then returns a per-requester acknowledge with the checker's error verdict. A watchdog converts a missing done into a timed-out error response, and a saturating counter tracks total errors.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8
- `DATA_W`, 3 — checker word width
- `TIMEOUT`, 64 — max cycles in WAIT before forced error response, ≥4
- `CNT_W`, 8 — error counter width

- `i_clk`  in  1  — single clock, rising edge
- `i_rstn`  in  1  — asynchronous active-low reset
- `i_req`  in  N_REQ  — request level per requester; held until `o_ack`
- `i_req_data`  in  N_REQ*DATA_W  — requester k word in bits [k*DATA_W +: DATA_W]
- `o_ack`  out  N_REQ  — one-hot, one-cycle completion pulse
- `o_err`  out  1  — verdict; valid only while any `o_ack` bit is high
- `o_chk_flag`  out  1  — to checker `i_flag`; one-cycle pulse
- `o_chk_data`  out  DATA_W  — to checker `i_data`; held from issue until response
- `i_chk_err`  in  1  — checker `o_ERR`
- `i_chk_done`  in  1  — checker `o_ERR_done`; level or pulse, rising edge used
- `o_busy`  out  1  — high in every state except IDLE
- `o_timeout`  out  1  — one-cycle pulse when the watchdog fires
- `o_err_total`  out  CNT_W  — saturating count of error responses

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `i_req` bit is set, grant the first set bit at or after `rr_ptr`, searching cyclically. Latch the grant index and `i_req_data` slice, then go to ISSUE.
- **ISSUE:** `o_chk_flag`=1 for exactly one cycle, with `o_chk_data` = latched word. Clear the watchdog and go to WAIT.
- **WAIT:** `done_evt` = `i_chk_done` & ~`done_q`, where `done_q` is `i_chk_done` registered every cycle.
  - On `done_evt`, latch `i_chk_err` from the same cycle and go to RESP.
  - Otherwise increment the watchdog. When it reaches `TIMEOUT`-1, latch err=1, pulse `o_timeout` and go to RESP.
- **RESP:** `o_ack[grant]`=1 and `o_err` = latched err. Set `rr_ptr` = grant+1 (wraps to 0 at `N_REQ`). If err=1 and `o_err_total` < 2^CNT_W-1, increment the counter. Return to IDLE.
- Data is latched at grant. Later changes to `i_req_data` or a dropped `i_req` do not abort the transaction; the ack is still issued.
- A done that is already high when WAIT is entered is not an event; only a rising edge counts.
- Simultaneous `done_evt` and watchdog expiry: the done wins, `i_chk_err` is used, and there is no `o_timeout`.
- `i_chk_done`/`i_chk_err` activity outside WAIT is ignored, but `done_q` still tracks.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, all outputs 0, `o_err_total`=0, `done_q`=0.
- Request seen in IDLE at cycle t: ISSUE at t+1 (flag high), WAIT from t+2.
- `done_evt` at cycle d: `o_ack` at d+1, IDLE at d+2. Next grant is possible at d+2, flag at d+3.
- Minimum round trip is 4 cycles from request to ack.
- Timeout: `o_timeout` and `o_ack` are asserted in the same RESP cycle, `TIMEOUT` cycles after entering WAIT.
- Reset mid-transaction: immediate return to reset values. No ack is issued and the checker is not notified.

## Structure
- Shared package/include `bit_akis_pkg`: state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and the default `DATA_W`=3.
- Sub-module `rr_arbiter`: combinational rotating-priority picker.
  - Inputs: `req`[N_REQ], `ptr`.
  - Outputs: one-hot `gnt` and `gnt_idx`.
- The top level holds the FSM, data latch, watchdog and counter.

## Test plan
- **Single requester:** `i_req`=0001, data=3'b101, checker model done after 5 cycles with err=0. Required: flag exactly once with `o_chk_data`=5, then `o_ack`=0001 with `o_err`=0 at done+1, and `o_err_total`=0.
- **All four requesting continuously:** ack order is 0,1,2,3,0. Each ack carries its own requester's data verdict, and `o_chk_flag` never asserts while in WAIT.
- **Checker never raises done (`TIMEOUT`=16):** `o_timeout` and `o_ack` pulse 16 cycles after WAIT entry with `o_err`=1, and `o_err_total` increments to 1.
- **`i_chk_done` held high from the previous transaction:** the next transaction waits for a fresh rising edge and does not complete in 1 cycle.
- **Saturation (`CNT_W`=2):** five err=1 responses leave `o_err_total` at 3.
- **Reset asserted during WAIT:** all outputs are 0 within the same cycle. After release, requester 0 is granted first even if the last grant was 2.
